// File: rtl/count_pkg.sv
// Shared types and constants for the up/down count rate controller.
package count_pkg;

  localparam int unsigned PRESCALE_W = 27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

endpackage

// File: rtl/count_rate_ctrl_if.sv
// Key/rate inputs, digit feedback and step strobes between controller and datapath.
interface count_rate_ctrl_if;

  logic       sw_rate;
  logic       key_up;
  logic       key_dn;
  logic [3:0] ones_digit;
  logic [3:0] tens_digit;
  logic       ones_inc;
  logic       ones_dec;
  logic       tens_inc;
  logic       tens_dec;
  logic       wrap;
  logic [1:0] state;

  modport slave (
    input  sw_rate, key_up, key_dn, ones_digit, tens_digit,
    output ones_inc, ones_dec, tens_inc, tens_dec, wrap, state
  );

  modport master (
    output sw_rate, key_up, key_dn, ones_digit, tens_digit,
    input  ones_inc, ones_dec, tens_inc, tens_dec, wrap, state
  );

endinterface

// File: rtl/count_rate_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/count_rate_ctrl.sv
// Key-driven up/down step controller for a two-digit BCD counter with
// selectable step rate; emits registered one-cycle inc/dec/carry/wrap strobes.
module count_rate_ctrl
  import count_pkg::*;
#(
  parameter int unsigned FAST_DIV = 50000000,
  parameter int unsigned SLOW_DIV = 100000000
) (
  input logic             clk,
  input logic             rst,
  count_rate_ctrl_if.slave bus
);

  logic w_up_s;
  logic w_dn_s;
  logic w_rate_s;

  sync2 u_sync_up   (.i_clk(clk), .i_rst(rst), .i_d(bus.key_up),  .o_q(w_up_s));
  sync2 u_sync_dn   (.i_clk(clk), .i_rst(rst), .i_d(bus.key_dn),  .o_q(w_dn_s));
  sync2 u_sync_rate (.i_clk(clk), .i_rst(rst), .i_d(bus.sw_rate), .o_q(w_rate_s));

  state_t                r_state;
  state_t                w_next;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] w_div_m1;
  logic                  r_rate_q;
  logic                  w_rate_chg;
  logic                  w_run;
  logic                  w_tick;
  logic                  w_step;

  logic w_ones_inc, w_ones_dec, w_tens_inc, w_tens_dec, w_wrap;
  logic r_ones_inc, r_ones_dec, r_tens_inc, r_tens_dec, r_wrap;

  assign w_div_m1   = w_rate_s ? PRESCALE_W'(SLOW_DIV - 1) : PRESCALE_W'(FAST_DIV - 1);
  assign w_run      = (r_state == UP) || (r_state == DOWN);
  assign w_rate_chg = (w_rate_s != r_rate_q);
  assign w_tick     = w_run && (r_cnt == w_div_m1);
  // A tick loses to a state exit or a rate change, both of which restart the period.
  assign w_step     = w_tick && (w_next == r_state) && !w_rate_chg;

  always_comb begin
    w_next     = r_state;
    w_ones_inc = 1'b0;
    w_ones_dec = 1'b0;
    w_tens_inc = 1'b0;
    w_tens_dec = 1'b0;
    w_wrap     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_up_s && !w_dn_s)      w_next = UP;
        else if (w_dn_s && !w_up_s) w_next = DOWN;
      end
      UP: begin
        if (!w_up_s || w_dn_s) w_next = IDLE;
      end
      DOWN: begin
        if (!w_dn_s || w_up_s) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase

    if (w_step && (r_state == UP)) begin
      w_ones_inc = 1'b1;
      w_tens_inc = (bus.ones_digit == 4'd9);
      w_wrap     = (bus.ones_digit == 4'd9) && (bus.tens_digit == 4'd9);
    end else if (w_step && (r_state == DOWN)) begin
      w_ones_dec = 1'b1;
      w_tens_dec = (bus.ones_digit == 4'd0);
      w_wrap     = (bus.ones_digit == 4'd0) && (bus.tens_digit == 4'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rate_q <= 1'b0;
    end else begin
      r_rate_q <= w_rate_s;
      if (!w_run || (w_next != r_state) || w_rate_chg || w_tick) r_cnt <= '0;
      else                                                       r_cnt <= r_cnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones_inc <= 1'b0;
      r_ones_dec <= 1'b0;
      r_tens_inc <= 1'b0;
      r_tens_dec <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_ones_inc <= w_ones_inc;
      r_ones_dec <= w_ones_dec;
      r_tens_inc <= w_tens_inc;
      r_tens_dec <= w_tens_dec;
      r_wrap     <= w_wrap;
    end
  end

  assign bus.ones_inc = r_ones_inc;
  assign bus.ones_dec = r_ones_dec;
  assign bus.tens_inc = r_tens_inc;
  assign bus.tens_dec = r_tens_dec;
  assign bus.wrap     = r_wrap;
  assign bus.state    = r_state;

endmodule
